butterfly_pipe: RTL and testbench

- Pipelined, parametrised successor to the combinational radix-2 butterfly_sum used in the FFT datapath.
- Computes one complex radix-2 butterfly per cycle on signed fixed-point operands packed as {real, imag}.
- Adds a valid/ready handshake, DIT/DIF mode select, optional per-stage scale-by-half, round-half-up and saturation.
- Sits between the FFT operand memory read port and its write-back path.

---
 rtl/butterfly_pkg.sv | 56 +++++
 rtl/complex_mult_pipe.sv | 85 ++++++++
 rtl/butterfly_pipe.sv | 172 +++++++++++++++++
 tb/tb_butterfly_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/butterfly_pkg.sv
// Shared constants, types and arithmetic helpers for the radix-2 butterfly datapath.
package butterfly_pkg;

  // Default operand geometry: signed Q(HALF_SIZE-FRACT_PT).FRACT_PT components.
  localparam int unsigned HALF_SIZE = 37;
  localparam int unsigned FRACT_PT  = 18;
  localparam int unsigned WORD_SIZE = 2 * HALF_SIZE;

  // Butterfly flavour carried with each operand set.
  localparam logic MODE_DIT = 1'b0;
  localparam logic MODE_DIF = 1'b1;

  // Helpers work on a generously wide signed container so callers of any width can share them.
  localparam int unsigned WIDE = 128;
  typedef logic signed [WIDE-1:0] wide_t;

  typedef struct packed {
    logic  hit;
    wide_t val;
  } sat_t;

  // Round half-up then arithmetic shift right by sh; sh = 0 passes the value through.
  function automatic wide_t round_shift(input wide_t v, input int unsigned sh);
    wide_t bias;
    wide_t sum;
    wide_t r;
    if (sh == 0) begin
      r = v;
    end else begin
      bias = wide_t'(1) << (sh - 1);
      sum  = v + bias;
      r    = sum >>> sh;
    end
    return r;
  endfunction

  // Clamp to the signed range of a half-width component and report whether clamping happened.
  function automatic sat_t sat_half(input wide_t v, input int unsigned half);
    wide_t hi;
    wide_t lo;
    sat_t  r;
    hi    = (wide_t'(1) << (half - 1)) - wide_t'(1);
    lo    = ~hi;
    r.hit = 1'b1;
    r.val = v;
    if (v > hi) begin
      r.val = hi;
    end else if (v < lo) begin
      r.val = lo;
    end else begin
      r.hit = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/complex_mult_pipe.sv
// Two-stage complex multiply P = X * W with half-up rounding of the fixed-point product.
// Stage 1 registers the four partial products, stage 2 combines, rounds and narrows them.
module complex_mult_pipe
  import butterfly_pkg::*;
#(
  parameter int unsigned XW    = butterfly_pkg::HALF_SIZE + 1,
  parameter int unsigned WW    = butterfly_pkg::HALF_SIZE,
  parameter int unsigned OW    = butterfly_pkg::HALF_SIZE + 2,
  parameter int unsigned FRACT = butterfly_pkg::FRACT_PT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 adv,
  input  logic                 in_valid,
  input  logic signed [XW-1:0] x_re,
  input  logic signed [XW-1:0] x_im,
  input  logic signed [WW-1:0] w_re,
  input  logic signed [WW-1:0] w_im,
  output logic                 out_valid,
  output logic signed [OW-1:0] p_re,
  output logic signed [OW-1:0] p_im
);

  localparam int unsigned PW = XW + WW;

  logic                 s1_valid;
  logic signed [PW-1:0] xr_e, xi_e, wr_e, wi_e;
  logic signed [PW-1:0] rr_q, ii_q, ri_q, ir_q;
  wide_t                rr_w, ii_w, ri_w, ir_w;
  wide_t                pr_w, pi_w, pr_r, pi_r;
  logic                 unused_round;

  // Sign-extend operands to product width so the multiply is full precision.
  always_comb begin
    xr_e = {{WW{x_re[XW-1]}}, x_re};
    xi_e = {{WW{x_im[XW-1]}}, x_im};
    wr_e = {{XW{w_re[WW-1]}}, w_re};
    wi_e = {{XW{w_im[WW-1]}}, w_im};
  end

  // Stage 1: register the four partial products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      rr_q     <= '0;
      ii_q     <= '0;
      ri_q     <= '0;
      ir_q     <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      rr_q     <= xr_e * wr_e;
      ii_q     <= xi_e * wi_e;
      ri_q     <= xr_e * wi_e;
      ir_q     <= xi_e * wr_e;
    end
  end

  // Combine partial products, round half-up and drop the fractional bits.
  always_comb begin
    rr_w         = {{(WIDE - PW){rr_q[PW-1]}}, rr_q};
    ii_w         = {{(WIDE - PW){ii_q[PW-1]}}, ii_q};
    ri_w         = {{(WIDE - PW){ri_q[PW-1]}}, ri_q};
    ir_w         = {{(WIDE - PW){ir_q[PW-1]}}, ir_q};
    pr_w         = rr_w - ii_w;
    pi_w         = ri_w + ir_w;
    pr_r         = round_shift(pr_w, FRACT);
    pi_r         = round_shift(pi_w, FRACT);
    // Upper bits are sign copies for in-range data; only OW bits are kept.
    unused_round = ^{pr_r[WIDE-1:OW], pi_r[WIDE-1:OW]};
  end

  // Stage 2: register the rounded product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p_re      <= '0;
      p_im      <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      p_re      <= pr_r[OW-1:0];
      p_im      <= pi_r[OW-1:0];
    end
  end

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage pipelined radix-2 complex butterfly (DIT or DIF per operand set) with
// valid/ready flow control, optional divide-by-two, half-up rounding and saturation.
module butterfly_pipe #(
  parameter int unsigned HALF_SIZE = butterfly_pkg::HALF_SIZE,
  parameter int unsigned WORD_SIZE = 2 * HALF_SIZE,
  parameter int unsigned FRACT_PT  = butterfly_pkg::FRACT_PT
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WORD_SIZE-1:0] i_A,
  input  logic [WORD_SIZE-1:0] i_B,
  input  logic [WORD_SIZE-1:0] i_twiddle,
  input  logic                 i_mode,
  input  logic                 i_scale,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WORD_SIZE-1:0] o_A,
  output logic [WORD_SIZE-1:0] o_B,
  output logic                 o_sat
);

  import butterfly_pkg::*;

  // XW holds a sum/difference of two components, OW the rounded product and final sums.
  localparam int unsigned XW = HALF_SIZE + 1;
  localparam int unsigned OW = HALF_SIZE + 2;
  localparam logic signed [OW-1:0] OneOw = OW'(1);

  logic adv;

  logic signed [HALF_SIZE-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic signed [XW-1:0]        a_re_x, a_im_x, b_re_x, b_im_x;
  logic signed [XW-1:0]        x_re, x_im, c_re, c_im;

  // Pass-through operand: A for DIT, A+B for DIF, travelling beside the multiplier.
  logic signed [XW-1:0] c1_re, c1_im, c2_re, c2_im;
  logic                 mode1, scale1, mode2, scale2;

  logic                 s2_valid;
  logic signed [OW-1:0] p_re, p_im;

  logic signed [OW-1:0]        c_re_e, c_im_e, tmp;
  logic signed [OW-1:0]        res [4];
  logic signed [HALF_SIZE-1:0] outc [4];
  logic [3:0]                  hit;
  wide_t                       wv;
  sat_t                        st;
  logic                        unused_sat;

  // Whole pipe moves together; it only holds while a finished result waits downstream.
  assign adv     = !o_valid | i_ready;
  assign o_ready = adv;

  assign a_re = i_A[WORD_SIZE-1:HALF_SIZE];
  assign a_im = i_A[HALF_SIZE-1:0];
  assign b_re = i_B[WORD_SIZE-1:HALF_SIZE];
  assign b_im = i_B[HALF_SIZE-1:0];
  assign w_re = i_twiddle[WORD_SIZE-1:HALF_SIZE];
  assign w_im = i_twiddle[HALF_SIZE-1:0];

  // Form the multiplier operand and the pass-through operand for the selected mode.
  always_comb begin
    a_re_x = {a_re[HALF_SIZE-1], a_re};
    a_im_x = {a_im[HALF_SIZE-1], a_im};
    b_re_x = {b_re[HALF_SIZE-1], b_re};
    b_im_x = {b_im[HALF_SIZE-1], b_im};
    if (i_mode == MODE_DIF) begin
      x_re = a_re_x - b_re_x;
      x_im = a_im_x - b_im_x;
      c_re = a_re_x + b_re_x;
      c_im = a_im_x + b_im_x;
    end else begin
      x_re = b_re_x;
      x_im = b_im_x;
      c_re = a_re_x;
      c_im = a_im_x;
    end
  end

  complex_mult_pipe #(
    .XW    (XW),
    .WW    (HALF_SIZE),
    .OW    (OW),
    .FRACT (FRACT_PT)
  ) u_mult (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .adv       (adv),
    .in_valid  (i_valid),
    .x_re      (x_re),
    .x_im      (x_im),
    .w_re      (w_re),
    .w_im      (w_im),
    .out_valid (s2_valid),
    .p_re      (p_re),
    .p_im      (p_im)
  );

  // Carry the pass-through operand and per-item controls through stages 1 and 2.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      c1_re  <= '0;
      c1_im  <= '0;
      mode1  <= MODE_DIT;
      scale1 <= 1'b0;
      c2_re  <= '0;
      c2_im  <= '0;
      mode2  <= MODE_DIT;
      scale2 <= 1'b0;
    end else if (adv) begin
      c1_re  <= c_re;
      c1_im  <= c_im;
      mode1  <= i_mode;
      scale1 <= i_scale;
      c2_re  <= c1_re;
      c2_im  <= c1_im;
      mode2  <= mode1;
      scale2 <= scale1;
    end
  end

  // Stage 3 datapath: final add/subtract, optional halving, then clamp each component.
  always_comb begin
    c_re_e     = {c2_re[XW-1], c2_re};
    c_im_e     = {c2_im[XW-1], c2_im};
    tmp        = '0;
    wv         = '0;
    st         = '0;
    hit        = '0;
    unused_sat = 1'b0;
    if (mode2 == MODE_DIF) begin
      res[0] = c_re_e;
      res[1] = c_im_e;
      res[2] = p_re;
      res[3] = p_im;
    end else begin
      res[0] = c_re_e + p_re;
      res[1] = c_im_e + p_im;
      res[2] = c_re_e - p_re;
      res[3] = c_im_e - p_im;
    end
    for (int k = 0; k < 4; k++) begin
      if (scale2) begin
        tmp    = res[k] + OneOw;
        res[k] = tmp >>> 1;
      end
      wv         = {{(WIDE - OW){res[k][OW-1]}}, res[k]};
      st         = sat_half(wv, HALF_SIZE);
      outc[k]    = st.val[HALF_SIZE-1:0];
      hit[k]     = st.hit;
      unused_sat = unused_sat ^ (^st.val[WIDE-1:HALF_SIZE]);
    end
  end

  // Output register: holds its result until downstream takes it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_A     <= '0;
      o_B     <= '0;
      o_sat   <= 1'b0;
    end else if (adv) begin
      o_valid <= s2_valid;
      o_A     <= {outc[0], outc[1]};
      o_B     <= {outc[2], outc[3]};
      o_sat   <= |hit;
    end
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Bench for butterfly_pipe: directed vectors, a complex-arithmetic reference model feeding a
// scoreboard, literal checks that pin the model, backpressure and mid-flight reset.
module tb_butterfly_pipe;

  localparam int H = 37;
  localparam int W = 74;
  localparam longint ONE = 64'sd262144;
  localparam longint MAXP = 64'sd68719476735;   // 2^36 - 1
  localparam longint MINN = -64'sd68719476736;  // -2^36

  typedef logic signed [127:0] big_t;
  typedef struct {
    longint a_re, a_im, b_re, b_im, w_re, w_im;
    logic   mode, scale;
  } item_t;
  typedef struct {
    longint oa_re, oa_im, ob_re, ob_im;
    logic   sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_valid = 1'b0, i_ready = 1'b1, i_mode = 1'b0, i_scale = 1'b0;
  logic [W-1:0] i_A = '0, i_B = '0, i_tw = '0;
  logic o_ready, o_valid, o_sat;
  logic [W-1:0] o_A, o_B;

  int n_cmp = 0;
  int n_err = 0;
  int n_drained = 0;
  exp_t q[$];
  item_t cur;

  butterfly_pipe dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_A       (i_A),
    .i_B       (i_B),
    .i_twiddle (i_tw),
    .i_mode    (i_mode),
    .i_scale   (i_scale),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_A       (o_A),
    .o_B       (o_B),
    .o_sat     (o_sat)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: plain complex arithmetic ----------------
  function automatic big_t rnd(input big_t v);
    return (v + 128'sd131072) >>> 18;
  endfunction

  function automatic big_t fin(input big_t v, input logic sc, inout logic hit);
    big_t t;
    t = sc ? ((v + 1) >>> 1) : v;
    if (t > big_t'(MAXP)) begin
      hit = 1'b1;
      t = big_t'(MAXP);
    end else if (t < big_t'(MINN)) begin
      hit = 1'b1;
      t = big_t'(MINN);
    end
    return t;
  endfunction

  function automatic exp_t model(input item_t it);
    big_t ar, ai, br, bi, wr, wi, xr, xi, pr, pi;
    big_t r0, r1, r2, r3;
    logic hit;
    exp_t e;
    ar = it.a_re; ai = it.a_im; br = it.b_re; bi = it.b_im; wr = it.w_re; wi = it.w_im;
    if (it.mode) begin
      xr = ar - br; xi = ai - bi;
    end else begin
      xr = br; xi = bi;
    end
    pr = rnd(xr * wr - xi * wi);
    pi = rnd(xr * wi + xi * wr);
    if (it.mode) begin
      r0 = ar + br; r1 = ai + bi; r2 = pr; r3 = pi;
    end else begin
      r0 = ar + pr; r1 = ai + pi; r2 = ar - pr; r3 = ai - pi;
    end
    hit = 1'b0;
    e.oa_re = longint'(fin(r0, it.scale, hit));
    e.oa_im = longint'(fin(r1, it.scale, hit));
    e.ob_re = longint'(fin(r2, it.scale, hit));
    e.ob_im = longint'(fin(r3, it.scale, hit));
    e.sat = hit;
    return e;
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] pack(input longint re, input longint im);
    logic [63:0] r, i;
    r = re;
    i = im;
    return {r[H-1:0], i[H-1:0]};
  endfunction

  function automatic longint up_re(input logic [W-1:0] v);
    logic signed [H-1:0] t;
    t = v[W-1:H];
    return longint'(t);
  endfunction

  function automatic longint up_im(input logic [W-1:0] v);
    logic signed [H-1:0] t;
    t = v[H-1:0];
    return longint'(t);
  endfunction

  function automatic item_t mk(input longint ar, input longint ai, input longint br,
                               input longint bi, input longint wr, input longint wi,
                               input logic md, input logic sc);
    item_t it;
    it.a_re = ar; it.a_im = ai; it.b_re = br; it.b_im = bi; it.w_re = wr; it.w_im = wi;
    it.mode = md; it.scale = sc;
    return it;
  endfunction

  function automatic exp_t ex(input longint a, input longint b, input longint c,
                              input longint d, input logic s);
    exp_t e;
    e.oa_re = a; e.oa_im = b; e.ob_re = c; e.ob_im = d; e.sat = s;
    return e;
  endfunction

  task automatic chk(input string nm, input longint got, input longint expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, expv);
    end
  endtask

  task automatic apply(input item_t it);
    cur = it;
    i_A = pack(it.a_re, it.a_im);
    i_B = pack(it.b_re, it.b_im);
    i_tw = pack(it.w_re, it.w_im);
    i_mode = it.mode;
    i_scale = it.scale;
    i_valid = 1'b1;
  endtask

  // Present one item (called at a falling edge) and hold it until it is accepted.
  task automatic drive(input item_t it);
    int g;
    apply(it);
    #1;
    g = 0;
    while (!o_ready && g < 50) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 50) chk("drive accept timeout", longint'(o_ready), 1);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic pin(input string nm, input item_t it, input exp_t lit);
    exp_t e;
    e = model(it);
    chk({nm, " model oA.re"}, e.oa_re, lit.oa_re);
    chk({nm, " model oA.im"}, e.oa_im, lit.oa_im);
    chk({nm, " model oB.re"}, e.ob_re, lit.ob_re);
    chk({nm, " model oB.im"}, e.ob_im, lit.ob_im);
    chk({nm, " model sat"}, longint'(e.sat), longint'(lit.sat));
  endtask

  // Single item into an idle pipe: latency and hand-computed result.
  task automatic send_alone(input string nm, input item_t it, input exp_t lit);
    int lat;
    @(negedge clk);
    apply(it);
    #1;
    chk({nm, " o_ready idle"}, longint'(o_ready), 1);
    @(negedge clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, lat, 3);
    chk({nm, " oA.re"}, up_re(o_A), lit.oa_re);
    chk({nm, " oA.im"}, up_im(o_A), lit.oa_im);
    chk({nm, " oB.re"}, up_re(o_B), lit.ob_re);
    chk({nm, " oB.im"}, up_im(o_B), lit.ob_im);
    chk({nm, " o_sat"}, longint'(o_sat), longint'(lit.sat));
  endtask

  // ---------------- scoreboard compare process ----------------
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious output: o_valid=1 with nothing outstanding");
        end else begin
          e = q.pop_front();
          chk("sb oA.re", up_re(o_A), e.oa_re);
          chk("sb oA.im", up_im(o_A), e.oa_im);
          chk("sb oB.re", up_re(o_B), e.ob_re);
          chk("sb oB.im", up_im(o_B), e.ob_im);
          chk("sb o_sat", longint'(o_sat), longint'(e.sat));
          n_drained++;
        end
      end
      if (i_valid && o_ready) q.push_back(model(cur));
    end
  end

  // ---------------- directed sequence ----------------
  item_t v1, v2, v3, v4a, v4b, vr1, vr2, vneg, vdif;
  item_t stream [8];

  initial begin
    int g;
    int base;
    logic saw_stall;

    v1  = mk(ONE, 2 * ONE, 3 * ONE, 4 * ONE, ONE, 0, 1'b0, 1'b0);
    v2  = mk(ONE, 0, 0, ONE, 0, ONE, 1'b0, 1'b1);
    v3  = mk(2 * ONE, 0, ONE, ONE, 0, -ONE, 1'b1, 1'b0);
    v4a = mk(MAXP, 0, ONE, 0, ONE, 0, 1'b0, 1'b0);
    v4b = mk(MAXP, 0, ONE, 0, ONE, 0, 1'b0, 1'b1);
    vr1 = mk(0, 0, 1, 0, ONE / 2, 0, 1'b0, 1'b0);      // exact half rounds up
    vr2 = mk(0, 0, -1, 0, ONE / 2, 0, 1'b0, 1'b0);     // -half rounds up to zero
    vneg = mk(MINN, 0, -ONE, 0, ONE, 0, 1'b0, 1'b0);   // negative clamp
    vdif = mk(5 * ONE, 3 * ONE, -ONE, 2 * ONE, ONE / 2, ONE / 2, 1'b1, 1'b1);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset o_valid", longint'(o_valid), 0);
    chk("reset o_A", longint'(o_A != '0), 0);
    chk("reset o_B", longint'(o_B != '0), 0);
    chk("reset o_sat", longint'(o_sat), 0);
    rst_n = 1'b1;
    #1;
    chk("o_ready after reset", longint'(o_ready), 1);

    // Hand-computed literals pin the model.
    pin("v1", v1, ex(4 * ONE, 6 * ONE, -2 * ONE, -2 * ONE, 1'b0));
    pin("v2", v2, ex(0, 0, ONE, 0, 1'b0));
    pin("v3", v3, ex(3 * ONE, ONE, -ONE, -ONE, 1'b0));
    pin("v4a", v4a, ex(MAXP, 0, 64'sd68719214591, 0, 1'b1));
    pin("v4b", v4b, ex(64'sd34359869440, 0, 64'sd34359607296, 0, 1'b0));
    pin("vr1", vr1, ex(1, 0, -1, 0, 1'b0));
    pin("vr2", vr2, ex(0, 0, 0, 0, 1'b0));

    // Single items against literals.
    send_alone("dit unity", v1, ex(4 * ONE, 6 * ONE, -2 * ONE, -2 * ONE, 1'b0));
    send_alone("dit scale", v2, ex(0, 0, ONE, 0, 1'b0));
    send_alone("dif", v3, ex(3 * ONE, ONE, -ONE, -ONE, 1'b0));
    send_alone("sat", v4a, ex(MAXP, 0, 64'sd68719214591, 0, 1'b1));
    send_alone("sat scaled", v4b, ex(64'sd34359869440, 0, 64'sd34359607296, 0, 1'b0));
    send_alone("round half", vr1, ex(1, 0, -1, 0, 1'b0));

    // Back-to-back stream with a 4-cycle downstream stall.
    stream = '{v1, v2, v3, v4a, vr2, vneg, vdif, v4b};
    repeat (2) @(negedge clk);
    base = n_drained;
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) drive(stream[i]);
      end
      begin
        repeat (3) @(negedge clk);
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          #1;
          if (!o_ready) saw_stall = 1'b1;
          @(negedge clk);
        end
        i_ready = 1'b1;
      end
    join
    g = 0;
    while (q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    chk("stream drained count", n_drained - base, 8);
    chk("stream o_ready stalled", longint'(saw_stall), 1);
    chk("stream scoreboard empty", q.size(), 0);

    // Reset with items in flight.
    for (int i = 0; i < 3; i++) drive(stream[i]);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async reset o_valid", longint'(o_valid), 0);
    chk("async reset o_sat", longint'(o_sat), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no stale output after reset", longint'(o_valid), 0);
    end
    send_alone("post reset", v3, ex(3 * ONE, ONE, -ONE, -ONE, 1'b0));
    repeat (3) @(negedge clk);
    chk("final scoreboard empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
